// File: rtl/spi_slave_rx_if.sv
// Pin and host-side bundle of the SPI slave receiver.
// The slave modport is the endpoint's view; master is the driving side.
interface spi_slave_rx_if #(
   parameter int WIDTH = 16
);
   localparam int CNT_W = $clog2(WIDTH) + 1;

   logic             SCLK;
   logic             CS_N;
   logic             MOSI;
   logic             MISO;
   logic [WIDTH-1:0] tx_data;
   logic             tx_load;
   logic [WIDTH-1:0] rx_data;
   logic             rx_valid;
   logic             frame_err;
   logic             busy;
   logic [CNT_W-1:0] bit_cnt;

   modport slave (
      input  SCLK, CS_N, MOSI, tx_data, tx_load,
      output MISO, rx_data, rx_valid, frame_err, busy, bit_cnt
   );

   modport master (
      output SCLK, CS_N, MOSI, tx_data, tx_load,
      input  MISO, rx_data, rx_valid, frame_err, busy, bit_cnt
   );
endinterface

// File: rtl/spi_slave_rx.sv
// SPI slave endpoint: oversamples SCLK/CS_N/MOSI on clk, deserialises a WIDTH-bit
// MSB-first frame and shifts a shadowed reply word out on MISO.
module spi_slave_rx #(
   parameter int WIDTH       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   spi_slave_rx_if.slave    bus
);
   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

   typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v >= CNT_FULL) return CNT_FULL;
      return v + CNT_W'(1);
   endfunction

   logic [SYNC_STAGES-1:0] sclk_sync;
   logic [SYNC_STAGES-1:0] cs_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic                   d_sclk;
   logic                   d_cs;

   state_t           state;
   logic [WIDTH-1:0] shadow;
   logic [WIDTH-1:0] tx_shift;
   logic [WIDTH-2:0] rx_shift;
   logic [WIDTH-1:0] rx_data_r;
   logic             rx_valid_r;
   logic             frame_err_r;
   logic             busy_r;
   logic [CNT_W-1:0] bit_cnt_r;

   logic             s_sclk, s_cs, s_mosi;
   logic             rise, fall, cs_fall, cs_rise;
   logic [WIDTH-1:0] rx_next;
   logic [CNT_W-1:0] cnt_next;

   // Equal-depth synchronisers keep SCLK, CS_N and MOSI mutually aligned.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sclk_sync <= '0;
         cs_sync   <= '1;
         mosi_sync <= '0;
         d_sclk    <= 1'b0;
         d_cs      <= 1'b1;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.SCLK};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.CS_N};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.MOSI};
         d_sclk    <= s_sclk;
         d_cs      <= s_cs;
      end
   end

   assign s_sclk   = sclk_sync[SYNC_STAGES-1];
   assign s_cs     = cs_sync[SYNC_STAGES-1];
   assign s_mosi   = mosi_sync[SYNC_STAGES-1];
   assign rise     = s_sclk & ~d_sclk;
   assign fall     = ~s_sclk & d_sclk;
   assign cs_fall  = ~s_cs & d_cs;
   assign cs_rise  = s_cs & ~d_cs;
   assign rx_next  = {rx_shift, s_mosi};
   assign cnt_next = sat_inc(bit_cnt_r);

   // Frame FSM; a rise in the same cycle as cs_rise is honoured before the close.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         shadow      <= '0;
         tx_shift    <= '0;
         rx_shift    <= '0;
         rx_data_r   <= '0;
         rx_valid_r  <= 1'b0;
         frame_err_r <= 1'b0;
         busy_r      <= 1'b0;
         bit_cnt_r   <= '0;
      end else begin
         rx_valid_r  <= 1'b0;
         frame_err_r <= 1'b0;
         if (bus.tx_load) shadow <= bus.tx_data;

         case (state)
            IDLE: begin
               if (cs_fall) begin
                  tx_shift  <= bus.tx_load ? bus.tx_data : shadow;
                  bit_cnt_r <= '0;
                  busy_r    <= 1'b1;
                  state     <= ACTIVE;
               end
            end

            ACTIVE: begin
               if (rise) begin
                  rx_shift  <= rx_next[WIDTH-2:0];
                  bit_cnt_r <= cnt_next;
                  if (cnt_next == CNT_FULL) begin
                     rx_data_r  <= rx_next;
                     rx_valid_r <= 1'b1;
                     state      <= DONE;
                     if (cs_rise) begin
                        state     <= IDLE;
                        busy_r    <= 1'b0;
                        bit_cnt_r <= '0;
                        tx_shift  <= '0;
                     end
                  end else if (cs_rise) begin
                     frame_err_r <= 1'b1;
                     state       <= IDLE;
                     busy_r      <= 1'b0;
                     bit_cnt_r   <= '0;
                     tx_shift    <= '0;
                  end
               end else if (cs_rise) begin
                  frame_err_r <= 1'b1;
                  state       <= IDLE;
                  busy_r      <= 1'b0;
                  bit_cnt_r   <= '0;
                  tx_shift    <= '0;
               end else if (fall && bit_cnt_r < CNT_FULL) begin
                  tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
               end
            end

            DONE: begin
               // MISO keeps the last bit; extra SCLK edges are ignored here.
               if (cs_rise) begin
                  state     <= IDLE;
                  busy_r    <= 1'b0;
                  bit_cnt_r <= '0;
                  tx_shift  <= '0;
               end
            end

            default: begin
               state  <= IDLE;
               busy_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.MISO      = tx_shift[WIDTH-1];
   assign bus.rx_data   = rx_data_r;
   assign bus.rx_valid  = rx_valid_r;
   assign bus.frame_err = frame_err_r;
   assign bus.busy      = busy_r;
   assign bus.bit_cnt   = bit_cnt_r;
endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: received words go through a scoreboard queue,
// MISO words and control outputs are compared against bench-side constants.
module tb_spi_slave_rx;
   localparam int WIDTH       = 16;
   localparam int SYNC_STAGES = 2;
   localparam int HALF        = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   spi_slave_rx_if #(.WIDTH(WIDTH)) bus ();

   spi_slave_rx #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int passed = 0;
   int valid_cnt = 0;
   int err_cnt = 0;
   logic [WIDTH-1:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   always @(negedge clk) begin
      if (reset === 1'b1 && bus.rx_valid === 1'b1) begin
         valid_cnt++;
         if (exp_q.size() == 0) check("rx_unexpected", 32'd1, 32'd0);
         else check("rx_data_sb", 32'(bus.rx_data), 32'(exp_q.pop_front()));
      end
      if (reset === 1'b1 && bus.frame_err === 1'b1) err_cnt++;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic sclk_pulse(input logic mosi_bit, output logic miso_bit);
      bus.MOSI = mosi_bit;
      tick(HALF);
      miso_bit = bus.MISO;
      bus.SCLK = 1'b1;
      tick(HALF);
      bus.SCLK = 1'b0;
   endtask

   task automatic load(input logic [WIDTH-1:0] val);
      bus.tx_data = val;
      bus.tx_load = 1'b1;
      tick(1);
      bus.tx_load = 1'b0;
   endtask

   task automatic frame(input logic [WIDTH-1:0] word, input int nbits,
                        input int load_at, input logic [WIDTH-1:0] load_val,
                        output logic [WIDTH-1:0] miso_word);
      logic m;
      logic b;
      int   idx;
      miso_word = '0;
      bus.CS_N = 1'b0;
      tick(SYNC_STAGES + 4);
      for (int i = 0; i < nbits; i++) begin
         if (i == load_at) load(load_val);
         idx = WIDTH - 1 - i;
         b = (i < WIDTH) ? word[idx] : 1'b0;
         sclk_pulse(b, m);
         if (i < WIDTH) miso_word[idx] = m;
      end
      tick(SYNC_STAGES + 4);
   endtask

   task automatic cs_close();
      bus.CS_N = 1'b1;
      tick(SYNC_STAGES + 4);
   endtask

   initial begin
      logic [WIDTH-1:0] m1, m2;
      logic             mb;
      int               v0, e0;

      reset = 1'b0;
      bus.CS_N = 1'b1;
      bus.SCLK = 1'b0;
      bus.MOSI = 1'b0;
      bus.tx_data = '0;
      bus.tx_load = 1'b0;
      tick(3);
      check("rst_miso", 32'(bus.MISO), 32'd0);
      check("rst_rx_data", 32'(bus.rx_data), 32'd0);
      check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
      check("rst_frame_err", 32'(bus.frame_err), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_bit_cnt", 32'(bus.bit_cnt), 32'd0);
      reset = 1'b1;
      tick(5);

      // Basic receive
      load(16'hA5C3);
      v0 = valid_cnt;
      exp_q.push_back(16'h1234);
      frame(16'h1234, 16, -1, '0, m1);
      check("basic_busy_open", 32'(bus.busy), 32'd1);
      check("basic_bit_cnt_full", 32'(bus.bit_cnt), 32'd16);
      cs_close();
      check("basic_miso", 32'(m1), 32'hA5C3);
      check("basic_valid_pulses", 32'(valid_cnt - v0), 32'd1);
      check("basic_rx_data", 32'(bus.rx_data), 32'h1234);
      check("basic_busy_closed", 32'(bus.busy), 32'd0);
      check("basic_bit_cnt_idle", 32'(bus.bit_cnt), 32'd0);

      // Back-to-back frames, shadow resent
      v0 = valid_cnt;
      exp_q.push_back(16'hFFFF);
      frame(16'hFFFF, 16, -1, '0, m1);
      cs_close();
      exp_q.push_back(16'h0001);
      frame(16'h0001, 16, -1, '0, m2);
      cs_close();
      check("b2b_miso1", 32'(m1), 32'hA5C3);
      check("b2b_miso2", 32'(m2), 32'hA5C3);
      check("b2b_valid_pulses", 32'(valid_cnt - v0), 32'd2);
      check("b2b_rx_data", 32'(bus.rx_data), 32'h0001);

      // Aborted frame after 9 bits
      v0 = valid_cnt;
      e0 = err_cnt;
      frame(16'hABCD, 9, -1, '0, m1);
      check("abort_bit_cnt_open", 32'(bus.bit_cnt), 32'd9);
      cs_close();
      check("abort_err_pulses", 32'(err_cnt - e0), 32'd1);
      check("abort_no_valid", 32'(valid_cnt - v0), 32'd0);
      check("abort_rx_data_kept", 32'(bus.rx_data), 32'h0001);
      check("abort_bit_cnt_idle", 32'(bus.bit_cnt), 32'd0);

      // Over-clocking: 20 pulses
      v0 = valid_cnt;
      e0 = err_cnt;
      exp_q.push_back(16'hBEEF);
      frame(16'hBEEF, 20, -1, '0, m1);
      check("over_bit_cnt_sat", 32'(bus.bit_cnt), 32'd16);
      check("over_valid_pulses", 32'(valid_cnt - v0), 32'd1);
      check("over_rx_data", 32'(bus.rx_data), 32'hBEEF);
      check("over_busy", 32'(bus.busy), 32'd1);
      check("over_miso", 32'(m1), 32'hA5C3);
      cs_close();
      check("over_bit_cnt_idle", 32'(bus.bit_cnt), 32'd0);
      check("over_no_err", 32'(err_cnt - e0), 32'd0);

      // tx_load mid-frame only affects the next frame
      exp_q.push_back(16'h1111);
      frame(16'h1111, 16, 8, 16'h5555, m1);
      cs_close();
      exp_q.push_back(16'h2222);
      frame(16'h2222, 16, -1, '0, m2);
      cs_close();
      check("midload_miso1", 32'(m1), 32'hA5C3);
      check("midload_miso2", 32'(m2), 32'h5555);

      // tx_load coincident with the synchronised CS fall bypasses the shadow
      bus.CS_N = 1'b0;
      tick(SYNC_STAGES);
      load(16'h3C96);
      exp_q.push_back(16'h0F0F);
      frame(16'h0F0F, 16, -1, '0, m1);
      cs_close();
      check("bypass_miso", 32'(m1), 32'h3C96);
      check("bypass_rx_data", 32'(bus.rx_data), 32'h0F0F);

      // Reset mid-frame
      e0 = err_cnt;
      bus.CS_N = 1'b0;
      tick(SYNC_STAGES + 4);
      for (int i = 0; i < 5; i++) sclk_pulse(1'b1, mb);
      tick(SYNC_STAGES + 2);
      check("rstmid_bit_cnt_before", 32'(bus.bit_cnt), 32'd5);
      #2;
      reset = 1'b0;
      bus.CS_N = 1'b1;
      bus.SCLK = 1'b0;
      #1;
      check("rstmid_miso", 32'(bus.MISO), 32'd0);
      check("rstmid_rx_data", 32'(bus.rx_data), 32'd0);
      check("rstmid_busy", 32'(bus.busy), 32'd0);
      check("rstmid_bit_cnt", 32'(bus.bit_cnt), 32'd0);
      check("rstmid_rx_valid", 32'(bus.rx_valid), 32'd0);
      tick(3);
      reset = 1'b1;
      tick(5);
      check("rstmid_no_err", 32'(err_cnt - e0), 32'd0);
      v0 = valid_cnt;
      exp_q.push_back(16'h00FF);
      frame(16'h00FF, 16, -1, '0, m1);
      cs_close();
      check("post_rst_valid", 32'(valid_cnt - v0), 32'd1);
      check("post_rst_rx_data", 32'(bus.rx_data), 32'h00FF);
      check("post_rst_miso_zero_shadow", 32'(m1), 32'h0000);

      check("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/spi_slave_rx.md
Name: spi_slave_rx

Overview:
- SPI slave endpoint on the far side of the team's SPI master.
- Consumes the master's SCLK, chip-select and serial data. Deserialises a WIDTH-bit frame, MSB first, into a parallel word. Simultaneously shifts a locally loaded reply word back out on MISO.
- Runs on the system clock `clk`. SCLK, CS and MOSI are oversampled through synchronisers; SCLK is never used as a clock.

Parameters:
- WIDTH, 16, frame length in bits (≥2).
- SYNC_STAGES, 2, flip-flop depth of the input synchronisers (≥2). The same depth is used for SCLK, CS_N and MOSI so they stay aligned.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- SCLK  in  1  serial clock from master; idle low.
- CS_N  in  1  slave select, active low; a frame is open while low.
- MOSI  in  1  serial data from master.
- MISO  out  1  serial data to master.
- tx_data  in  WIDTH  reply word.
- tx_load  in  1  one-cycle strobe; latches tx_data into the shadow register.
- rx_data  out  WIDTH  last complete received word.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- frame_err  out  1  one-cycle pulse on an aborted frame.
- busy  out  1  high while state is ACTIVE or DONE.
- bit_cnt  out  log2(WIDTH)+1  bits received in the current frame.

Behaviour:
- **Reset** (reset=0, asynchronous):
  - MISO=0, rx_data=0, rx_valid=0, frame_err=0, busy=0, bit_cnt=0.
  - tx shadow=0, shift registers=0, synchronisers=0 (CS_N chain=1), state=IDLE.
  - Reset asserted mid-frame aborts the frame silently; no frame_err.
- **Edge detection:**
  - s_sclk, s_cs, s_mosi are the synchroniser outputs; d_sclk, d_cs are one further register.
  - rise = s_sclk & ~d_sclk; fall = ~s_sclk & d_sclk.
  - cs_fall = ~s_cs & d_cs; cs_rise = s_cs & ~d_cs.
- **IDLE:**
  - busy=0, MISO=0.
  - On cs_fall: load tx shadow into tx_shift, MISO=tx shadow[WIDTH-1] from the next cycle, bit_cnt=0, go to ACTIVE.
- **ACTIVE:**
  - On rise: rx_shift <= {rx_shift[WIDTH-2:0], s_mosi}; bit_cnt +1.
  - If bit_cnt becomes WIDTH on that edge: next cycle rx_data = completed word, rx_valid=1 for exactly 1 cycle; go to DONE.
  - On fall (bit_cnt < WIDTH): tx_shift shifts left; MISO = new MSB.
  - On cs_rise with bit_cnt < WIDTH: frame_err=1 for 1 cycle, rx_data unchanged, go to IDLE.
- **DONE:**
  - Further SCLK edges are ignored. MISO holds the last bit. bit_cnt holds WIDTH.
  - On cs_rise: go to IDLE, bit_cnt=0.
- **Simultaneous events:**
  - If rise and cs_rise occur in the same cycle, the rise is processed first.
  - If that rise is the WIDTH-th bit, the frame completes: rx_valid fires, no frame_err, state goes to IDLE directly.
- **tx_load:**
  - Accepted in any state; overwrites the shadow the next cycle.
  - A load during a frame affects only the next frame. With no load, the previous shadow is resent.
  - tx_load in the same cycle as cs_fall: the new tx_data is used for that frame (bypass).
- **Latency and timing:**
  - Latency from a master SCLK rise at the pin to the internal shift is SYNC_STAGES+1 clk cycles.
  - Each SCLK level must be held ≥ SYNC_STAGES+2 clk cycles; the master's one-state-per-clk toggling of SCLK therefore requires the master to be clocked ≥4× slower, or `clk` to be ≥4× faster.
- **Arithmetic:** bit_cnt saturates at WIDTH; it never wraps.

Test Plan:
- **Basic receive:** tx_load with tx_data=16'hA5C3, then a frame sending MOSI=16'h1234 MSB first with SCLK half-period 4 clk → rx_valid pulses once, rx_data=16'h1234, MISO bit sequence captured on SCLK rises = 16'hA5C3, busy falls after CS_N high.
- **Back-to-back frames:** 16'hFFFF then 16'h0001 with no tx_load between → two rx_valid pulses with the matching data; MISO resends 16'hA5C3 on both frames.
- **Aborted frame:** CS_N rises after 9 bits → frame_err pulses 1 cycle, rx_valid stays 0, rx_data keeps the previous value, bit_cnt returns to 0.
- **Over-clocking:** 20 SCLK pulses in one frame of 16'hBEEF → rx_data=16'hBEEF after the 16th pulse, extra pulses ignored, bit_cnt=16 until CS_N high.
- **Reset mid-frame:** assert reset after 5 bits → all outputs return to reset values immediately (asynchronously). A subsequent full frame of 16'h00FF is received correctly.
- **tx_load mid-frame:** tx_load 16'h5555 during frame 1 → frame 1 MISO is unchanged; frame 2 MISO = 16'h5555.
